// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: serialises ldr/base/alu writebacks in program order.
// Latency: 1 cycle request->write through the buffer (0 cycles on idle buffer with WB_BYPASS_EN).
// Backpressure: registered stall whenever fewer than 3 free entries remain; stalled requests are dropped.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, the oldest request bypasses an empty, unstalled buffer and
//   writes the register file in the same cycle.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   w_en_*/w_addr_*/w_data_*      ldr, base and alu writeback requests
//   query_addr / query_hit        decode hazard check against buffered writes
//   w_en / w_addr / w_data        register-file write port
//   stall                         upstream hold; requests ignored while high
//   count                         occupied buffer entries (debug)
module regfile_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_en_ldr,
  input  logic [3:0]               w_addr_ldr,
  input  logic [31:0]              w_data_ldr,
  input  logic                     w_en_base,
  input  logic [3:0]               w_addr_base,
  input  logic [31:0]              w_data_base,
  input  logic                     w_en_alu,
  input  logic [3:0]               w_addr_alu,
  input  logic [31:0]              w_data_alu,
  input  logic [3:0]               query_addr,
  output logic                     query_hit,
  output logic                     w_en,
  output logic [3:0]               w_addr,
  output logic [31:0]              w_data,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q, stall_d;

  // Buffer storage is not reset: only entries covered by count are ever read.
  logic [3:0]  addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];

  // Request vectors, index 0 is oldest in program order.
  logic [2:0]  req_vld;
  logic [2:0]  enq_vld;
  logic [3:0]  req_addr [3];
  logic [31:0] req_data [3];
  logic [PW-1:0] pos [3];
  logic [1:0]  enq_cnt;
  logic        deq;
  logic        byp;
  logic [3:0]  byp_addr;
  logic [31:0] byp_data;

  always_comb begin
    req_addr[0] = w_addr_ldr;
    req_addr[1] = w_addr_base;
    req_addr[2] = w_addr_alu;
    req_data[0] = w_data_ldr;
    req_data[1] = w_data_base;
    req_data[2] = w_data_alu;
    req_vld     = {w_en_alu, w_en_base, w_en_ldr} & {3{~stall_q}};
  end

`ifdef WB_BYPASS_EN
  logic [2:0] oldest_1h;
  always_comb begin
    // Lowest set bit = oldest asserted request.
    oldest_1h = req_vld & (~req_vld + 3'd1);
    byp       = (count_q == '0) && (req_vld != 3'b000);
    enq_vld   = byp ? (req_vld & ~oldest_1h) : req_vld;
    byp_addr  = '0;
    byp_data  = '0;
    for (int k = 2; k >= 0; k--) begin
      if (req_vld[k]) begin
        byp_addr = req_addr[k];
        byp_data = req_data[k];
      end
    end
  end
`else
  always_comb begin
    byp      = 1'b0;
    enq_vld  = req_vld;
    byp_addr = '0;
    byp_data = '0;
  end
`endif

  always_comb begin
    // Each accepted request lands after the ones older than it this cycle.
    pos[0]  = tail_q;
    pos[1]  = tail_q + PW'({1'b0, enq_vld[0]});
    pos[2]  = tail_q + PW'({1'b0, enq_vld[0]} + {1'b0, enq_vld[1]});
    enq_cnt = {1'b0, enq_vld[0]} + {1'b0, enq_vld[1]} + {1'b0, enq_vld[2]};
    // Dequeue depends only on pre-enqueue occupancy.
    deq     = (count_q != '0);
    count_d = count_q + CW'(enq_cnt) - CW'(deq);
    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(enq_cnt);
    stall_d = (DEPTH_C - count_d) < CW'(3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (enq_vld[k]) begin
        addr_q[pos[k]] <= req_addr[k];
        data_q[pos[k]] <= req_data[k];
      end
    end
  end

  // Hazard query covers only entries already in the buffer.
  always_comb begin
    logic [PW-1:0] ofs;
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ofs = PW'(i) - head_q;
      if (({1'b0, ofs} < count_q) && (addr_q[i] == query_addr)) begin
        query_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_en   = deq | byp;
    w_addr = deq ? addr_q[head_q] : (byp ? byp_addr : '0);
    w_data = deq ? data_q[head_q] : (byp ? byp_data : '0);
    stall  = stall_q;
    count  = count_q;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        w_en_ldr, w_en_base, w_en_alu;
  logic [3:0]  w_addr_ldr, w_addr_base, w_addr_alu;
  logic [31:0] w_data_ldr, w_data_base, w_data_alu;
  logic [3:0]  query_addr;
  logic        query_hit;
  logic        w_en;
  logic [3:0]  w_addr;
  logic [31:0] w_data;
  logic        stall;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [35:0] obs_q [$];
  logic [35:0] exp_q [$];
  logic [31:0] rf [16];
  logic [2:0]  max_cnt;

  regfile_wb_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_en_ldr(w_en_ldr), .w_addr_ldr(w_addr_ldr), .w_data_ldr(w_data_ldr),
    .w_en_base(w_en_base), .w_addr_base(w_addr_base), .w_data_base(w_data_base),
    .w_en_alu(w_en_alu), .w_addr_alu(w_addr_alu), .w_data_alu(w_data_alu),
    .query_addr(query_addr), .query_hit(query_hit),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .stall(stall), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (count <= 3'd4) else $error("count exceeded depth: %0d", count);
      if (count > max_cnt) max_cnt = count;
      if (w_en) begin
        obs_q.push_back({w_addr, w_data});
        rf[w_addr] = w_data;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reqs(input logic el, input logic [3:0] al, input logic [31:0] dl,
                          input logic eb, input logic [3:0] ab, input logic [31:0] db,
                          input logic ea, input logic [3:0] aa, input logic [31:0] da);
    w_en_ldr = el;  w_addr_ldr = al;  w_data_ldr = dl;
    w_en_base = eb; w_addr_base = ab; w_data_base = db;
    w_en_alu = ea;  w_addr_alu = aa;  w_data_alu = da;
  endtask

  task automatic clr_reqs();
    set_reqs(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic check_obs(input string tag);
    check({tag, "_n"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    rst_n = 1'b0;
    query_addr = 4'd0;
    max_cnt = 3'd0;
    for (int r = 0; r < 16; r++) rf[r] = 32'd0;
    clr_reqs();

    // Reset state
    #3;
    check("rst_w_en", 64'(w_en), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_w_addr", 64'(w_addr), 64'd0);
    check("rst_w_data", 64'(w_data), 64'd0);
    check("rst_query", 64'(query_hit), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single ALU request: written the following cycle
    set_reqs(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h0000_00AA);
    #1;
    check("t1_same_cycle_w_en", 64'(w_en), 64'd0);
    step();
    clr_reqs();
    check("t1_w_en", 64'(w_en), 64'd1);
    check("t1_w_addr", 64'(w_addr), 64'd3);
    check("t1_w_data", 64'(w_data), 64'hAA);
    check("t1_count", 64'(count), 64'd1);
    step();
    check("t1_drained_w_en", 64'(w_en), 64'd0);
    check("t1_drained_count", 64'(count), 64'd0);

    // Three requesters same cycle, same destination r1
    obs_q.delete();
    exp_q.delete();
    set_reqs(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 1'b1, 4'd1, 32'h33);
    exp_q.push_back({4'd1, 32'h11});
    exp_q.push_back({4'd2, 32'h22});
    exp_q.push_back({4'd1, 32'h33});
    step();
    clr_reqs();
    check("t2_count", 64'(count), 64'd3);
    check("t2_stall", 64'(stall), 64'd1);
    for (int i = 0; i < 4; i++) step();
    check_obs("t2");
    check("t2_rf_r1", 64'(rf[1]), 64'h33);
    check("t2_rf_r2", 64'(rf[2]), 64'h22);
    check("t2_stall_clear", 64'(stall), 64'd0);

    // All three requesters every cycle: stall pattern and scoreboard
    obs_q.delete();
    exp_q.delete();
    max_cnt = 3'd0;
    for (int i = 0; i < 12; i++) begin
      logic [31:0] base_d;
      base_d = 32'hC000_0000 | (32'(i) << 8);
      check($sformatf("t3_stall%0d", i), 64'(stall), 64'((i % 3) != 0));
      if (!stall) begin
        exp_q.push_back({4'd4, base_d | 32'd0});
        exp_q.push_back({4'd5, base_d | 32'd1});
        exp_q.push_back({4'd6, base_d | 32'd2});
      end
      set_reqs(1'b1, 4'd4, base_d | 32'd0, 1'b1, 4'd5, base_d | 32'd1, 1'b1, 4'd6, base_d | 32'd2);
      step();
    end
    clr_reqs();
    for (int i = 0; i < 6; i++) step();
    check("t3_exp_size", 64'(exp_q.size()), 64'd12);
    check_obs("t3");
    check("t3_max_count", 64'(max_cnt), 64'd3);

    // Hazard query
    set_reqs(1'b1, 4'd7, 32'h77, 1'b1, 4'd5, 32'h55, 1'b1, 4'd6, 32'h66);
    query_addr = 4'd7;
    #1;
    check("t4_incoming_excluded", 64'(query_hit), 64'd0);
    step();
    clr_reqs();
    check("t4_hit_r7", 64'(query_hit), 64'd1);
    query_addr = 4'd8;
    #1;
    check("t4_miss_r8", 64'(query_hit), 64'd0);
    query_addr = 4'd6;
    #1;
    check("t4_hit_r6", 64'(query_hit), 64'd1);
    step();
    query_addr = 4'd7;
    #1;
    check("t4_r7_drained", 64'(query_hit), 64'd0);
    query_addr = 4'd5;
    #1;
    check("t4_hit_r5", 64'(query_hit), 64'd1);
    for (int i = 0; i < 3; i++) step();

    // Asynchronous reset with three entries buffered
    set_reqs(1'b1, 4'd9, 32'h99, 1'b1, 4'd10, 32'hAA, 1'b1, 4'd11, 32'hBB);
    step();
    clr_reqs();
    check("t5_count_before", 64'(count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_w_en", 64'(w_en), 64'd0);
    check("t5_count", 64'(count), 64'd0);
    check("t5_stall", 64'(stall), 64'd0);
    obs_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("t5_no_writes", 64'(obs_q.size()), 64'd0);
    check("t5_w_en_after", 64'(w_en), 64'd0);

    // Sustained single requester, 2*DEPTH+1 cycles: wraps pointers, no gaps
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      set_reqs(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'(15 - i), 32'h100 + 32'(i));
      exp_q.push_back({4'(15 - i), 32'h100 + 32'(i)});
      check($sformatf("t6_stall%0d", i), 64'(stall), 64'd0);
      if (i > 0) check($sformatf("t6_w_en%0d", i), 64'(w_en), 64'd1);
      if (i == 1) begin
        query_addr = 4'd15;
        #1;
        check("t6_hit_r15", 64'(query_hit), 64'd1);
      end
      step();
    end
    clr_reqs();
    check("t6_last_w_en", 64'(w_en), 64'd1);
    step();
    step();
    check_obs("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Owns the single register-file write port in the ARM32 pipeline. Three writeback requesters compete for that port: load data from the LDR writeback stage, ALU results, and base-register updates from pre/post-indexed LDR/STR. The block serialises them in program order through a small in-order buffer and raises a stall when the buffer cannot absorb a worst-case cycle. It also answers a decode-stage hazard query against writes that are still pending.

Parameters:
DEPTH, 4, write-buffer entries; power of two, minimum 4.

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
w_en_ldr  input  1  load writeback request
w_addr_ldr  input  4  load destination register
w_data_ldr  input  32  load data
w_en_base  input  1  base-register writeback request
w_addr_base  input  4  base register number
w_data_base  input  32  updated base address
w_en_alu  input  1  ALU writeback request
w_addr_alu  input  4  ALU destination register
w_data_alu  input  32  ALU result
query_addr  input  4  decode-stage source register to check
query_hit  output  1  query_addr matches a valid buffered entry
w_en  output  1  register-file write enable
w_addr  output  4  register-file write address
w_data  output  32  register-file write data
stall  output  1  upstream must hold; requests this cycle are ignored
count  output  log2(DEPTH)+1  occupied entries, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: FIFO empty, count=0, head/tail pointers 0, stall=0, w_en=0, w_addr=0, w_data=0, query_hit=0. Reset mid-operation discards all buffered entries with no write issued.
- Program order is fixed: ldr (oldest), then base, then alu (youngest).
- Accept: when stall=0, each asserted request this cycle is enqueued at the tail in program order, so 0 to 3 entries are enqueued per cycle. When stall=1, all requests are ignored and the requester must re-present them.
- Port drive: w_en=1 when the FIFO is non-empty. w_addr and w_data come from the head entry, so the port is driven combinationally from registered state. The head is dequeued every cycle in which w_en=1. Without the optional feature, latency is 1 cycle from request to write.
- Count update: count_next = count + enq - deq. Same-cycle enqueue and dequeue are both honoured. Dequeue uses the pre-enqueue head, so an empty FIFO never dequeues the entry it is enqueuing.
- Stall: stall is a register, set next cycle when (DEPTH - count_next) < 3; otherwise 0. This guarantees an unstalled cycle always has room for 3 entries, so overflow is impossible. Verification must assert that count never exceeds DEPTH.
- Pointers: head and tail wrap modulo DEPTH. Full and empty are distinguished by count, not by pointer equality.
- Same destination in one cycle: all entries are written in order, so the youngest value (alu) remains in the register file.
- query_hit: combinational OR over valid entries of (addr == query_addr). Incoming requests this cycle are excluded. query_addr=15 is treated like any other register.
- No arithmetic on data; data passes through unmodified.

Optional Feature:
WB_BYPASS_EN
- Defined: when the FIFO is empty and stall=0, the oldest asserted request drives w_en/w_addr/w_data combinationally in the same cycle and is not enqueued. The remaining requests are enqueued, so latency drops to 0 cycles on an idle buffer.
- Defined, query_hit: also matches bypassed-away entries? No; bypassed writes are already complete in that cycle and are not checked.
- Defined, stall and count: computed identically, using the enqueue count after bypass.
- Undefined: every write goes through the FIFO, as described in Behaviour.

Test Plan:
- Reset, then a single ALU request (r3, 0x0000_00AA) -> next cycle w_en=1, w_addr=3, w_data=0xAA. With WB_BYPASS_EN, the same cycle instead.
- Same-cycle ldr r1=0x11, base r2=0x22, alu r1=0x33 -> writes on three consecutive cycles in order r1=0x11, r2=0x22, r1=0x33. Final r1=0x33.
- DEPTH=4, all three requesters every cycle -> stall=1 after the first cycle. While stall=1, requests are ignored. Writes continue back-to-back, count never exceeds 4, and no entry is lost or duplicated (scoreboard check).
- Requests for r7 held in the buffer with query_addr=7 -> query_hit=1. query_addr=8 -> 0. After r7 drains, query_addr=7 -> 0.
- Fill to count=3, then assert rst_n=0 asynchronously mid-cycle -> w_en, stall and count go to 0 immediately, with no write after reset release.
- Sustained single-requester stream for 2*DEPTH+1 cycles -> pointers wrap, writes arrive in order with no gaps, and stall stays 0.
